visitor_direction_detector: RTL

//  Front end of the bidirectional visitor counter. Turns two raw IR beam sensors
//  (A = outer, B = inner) into clean one-cycle entry/exit pulses. These pulses

---
 rtl/visitor_direction_detector_pkg.sv | 21 ++
 rtl/visitor_direction_detector_if.sv | 34 +++
 rtl/visitor_direction_detector_sensor_debounce.sv | 40 ++++
 rtl/visitor_direction_detector.sv | 133 +++++++++++++
 4 files changed

// File: rtl/visitor_direction_detector_pkg.sv
// Shared definitions for the visitor counter front end.
// Holds the direction FSM state encoding (3-bit) and the default filter and timeout settings.
package visitor_direction_detector_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned DB_W_DEF            = 5;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 50000;
    localparam int unsigned TO_W_DEF            = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_A1      = 3'd1,
        ST_A2      = 3'd2,
        ST_A3      = 3'd3,
        ST_B1      = 3'd4,
        ST_B2      = 3'd5,
        ST_B3      = 3'd6,
        ST_WAITCLR = 3'd7
    } state_e;

endpackage

// File: rtl/visitor_direction_detector_if.sv
// Sensor and event bundle of the visitor direction detector.
//   sensor_a/sensor_b : raw beam inputs (1 = blocked), A outer, B inner
//   entry_pulse/exit_pulse : one-cycle pass events
//   busy : a pass is in progress
//   timeout_err : one-cycle stage-timeout event
// slave = detector side, master = sensor/consumer side.
interface visitor_direction_detector_if;

    logic sensor_a;
    logic sensor_b;
    logic entry_pulse;
    logic exit_pulse;
    logic busy;
    logic timeout_err;

    modport slave (
        input  sensor_a,
        input  sensor_b,
        output entry_pulse,
        output exit_pulse,
        output busy,
        output timeout_err
    );

    modport master (
        output sensor_a,
        output sensor_b,
        input  entry_pulse,
        input  exit_pulse,
        input  busy,
        input  timeout_err
    );

endinterface

// File: rtl/visitor_direction_detector_sensor_debounce.sv
// Two-flop synchroniser followed by a debounce filter for one raw beam sensor.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous sensor input
//   level      : filtered level, changes only after DEBOUNCE_CYCLES stable synced cycles
module visitor_direction_detector_sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DB_W            = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt;

    // Counter tracks how long the synced value has disagreed with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/visitor_direction_detector.sv
// Bidirectional visitor detector: filters both beam sensors and classifies each
// pass into a one-cycle entry (A->B) or exit (B->A) pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : sensors in, entry/exit/busy/timeout_err out (all outputs registered)
module visitor_direction_detector
    import visitor_direction_detector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DB_W            = DB_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int unsigned TO_W            = TO_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    visitor_direction_detector_if.slave   bus
);

    logic            fa;
    logic            fb;
    logic [1:0]      ab;
    state_e          state_q;
    state_e          state_nx;
    logic [TO_W-1:0] tmo_cnt;
    logic [TO_W-1:0] tmo_cnt_nx;
    logic            entry_nx;
    logic            exit_nx;
    logic            tmo_nx;

    visitor_direction_detector_sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W(DB_W)
    ) u_db_a (
        .clk(clk), .rst_n(rst_n), .raw(bus.sensor_a), .level(fa)
    );

    visitor_direction_detector_sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W(DB_W)
    ) u_db_b (
        .clk(clk), .rst_n(rst_n), .raw(bus.sensor_b), .level(fb)
    );

    assign ab = {fa, fb};

    // Next-state, pulse and timeout decode.
    always_comb begin
        state_nx   = state_q;
        entry_nx   = 1'b0;
        exit_nx    = 1'b0;
        tmo_nx     = 1'b0;
        tmo_cnt_nx = '0;
        case (state_q)
            ST_IDLE: begin
                if (ab == 2'b10)      state_nx = ST_A1;
                else if (ab == 2'b01) state_nx = ST_B1;
                else if (ab == 2'b11) state_nx = ST_WAITCLR;
            end
            ST_A1: begin
                if (ab == 2'b11)      state_nx = ST_A2;
                else if (ab == 2'b00) state_nx = ST_IDLE;
                else if (ab == 2'b01) state_nx = ST_WAITCLR;
            end
            ST_A2: begin
                if (ab == 2'b01)      state_nx = ST_A3;
                else if (ab == 2'b10) state_nx = ST_A1;
                else if (ab == 2'b00) state_nx = ST_WAITCLR;
            end
            ST_A3: begin
                if (ab == 2'b00) begin
                    state_nx = ST_IDLE;
                    entry_nx = 1'b1;
                end
                else if (ab == 2'b11) state_nx = ST_A2;
                else if (ab == 2'b10) state_nx = ST_WAITCLR;
            end
            ST_B1: begin
                if (ab == 2'b11)      state_nx = ST_B2;
                else if (ab == 2'b00) state_nx = ST_IDLE;
                else if (ab == 2'b10) state_nx = ST_WAITCLR;
            end
            ST_B2: begin
                if (ab == 2'b10)      state_nx = ST_B3;
                else if (ab == 2'b01) state_nx = ST_B1;
                else if (ab == 2'b00) state_nx = ST_WAITCLR;
            end
            ST_B3: begin
                if (ab == 2'b00) begin
                    state_nx = ST_IDLE;
                    exit_nx  = 1'b1;
                end
                else if (ab == 2'b11) state_nx = ST_B2;
                else if (ab == 2'b01) state_nx = ST_WAITCLR;
            end
            ST_WAITCLR: begin
                if (ab == 2'b00)      state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // A stalled stage overrides any decode and abandons the pass.
        if (state_q != ST_IDLE && state_q != ST_WAITCLR &&
            tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = ST_WAITCLR;
            entry_nx = 1'b0;
            exit_nx  = 1'b0;
            tmo_nx   = 1'b1;
        end

        if (state_nx == state_q && state_q != ST_IDLE && state_q != ST_WAITCLR) begin
            tmo_cnt_nx = tmo_cnt + TO_W'(1);
        end
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            tmo_cnt         <= '0;
            bus.busy        <= 1'b0;
            bus.entry_pulse <= 1'b0;
            bus.exit_pulse  <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state_q         <= state_nx;
            tmo_cnt         <= tmo_cnt_nx;
            bus.busy        <= (state_nx != ST_IDLE);
            bus.entry_pulse <= entry_nx;
            bus.exit_pulse  <= exit_nx;
            bus.timeout_err <= tmo_nx;
        end
    end

endmodule
